// File: rtl/io_poller_pkg.sv
// io_poller_pkg: shared widths, FSM state encoding and the masked-compare
// helper for the io_poller device-bus initiator.
//   DATA_W   : device bus data width
//   PERIOD_W : width of the inter-read idle period
//   TMO_W    : width of the ack timeout counter
// Optional feature macro: IO_POLLER_WRACT_EN adds the ST_WRITE state.
package io_poller_pkg;

    localparam int DATA_W   = 32;
    localparam int PERIOD_W = 16;
    localparam int TMO_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WAIT  = 2'd2
`ifdef IO_POLLER_WRACT_EN
        ,
        ST_WRITE = 2'd3
`endif
    } state_t;

    // True when every bit selected by mask agrees between value and pattern.
    function automatic logic masked_eq(input logic [DATA_W-1:0] value,
                                       input logic [DATA_W-1:0] pattern,
                                       input logic [DATA_W-1:0] mask);
        return ((value ^ pattern) & mask) == '0;
    endfunction

endpackage

// File: rtl/io_poller_cnt.sv
// io_poller_cnt: loadable down-counter with zero flag.
//   clk, rst     : clock, synchronous active-high reset (count -> 0)
//   load_i       : load load_val_i (has priority over decrement)
//   dec_i        : decrement by one, saturating at zero
//   load_val_i   : value to load
//   zero_o       : count is zero
module io_poller_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/io_poller.sv
// io_poller: device-bus initiator that polls one register until
// (rdata & mask) == (match & mask), flagging hit or ack timeout.
// Optional feature macro: IO_POLLER_WRACT_EN (one write action after a hit,
// adds cfg_wr_addr / cfg_wr_data inputs).
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   start, stop             : control pulses (start honoured only in IDLE)
//   cfg_addr/mask/match/period : poll configuration, latched on start
//   busy, hit, timeout      : status (hit/timeout are one-cycle pulses)
//   last_data               : last value read, unmasked
//   bus_stb/we/addr/wdata   : initiator side of the device bus
//   bus_rdata, bus_ack      : responder side of the device bus
//   dbg_state               : current FSM state
// Bus handshake: bus_stb is held with bus_we/bus_addr/bus_wdata stable until
// bus_ack; a transaction completes in the cycle where both are high, and
// bus_stb drops in the next cycle. bus_ack may be combinational from bus_stb.
module io_poller
    import io_poller_pkg::*;
#(
    parameter int addr_width = 4,
    parameter int tmo_cycles = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [addr_width-1:0] cfg_addr,
    input  logic [DATA_W-1:0]     cfg_mask,
    input  logic [DATA_W-1:0]     cfg_match,
    input  logic [PERIOD_W-1:0]   cfg_period,
`ifdef IO_POLLER_WRACT_EN
    input  logic [addr_width-1:0] cfg_wr_addr,
    input  logic [DATA_W-1:0]     cfg_wr_data,
`endif
    output logic                  busy,
    output logic                  hit,
    output logic                  timeout,
    output logic [DATA_W-1:0]     last_data,
    output logic                  bus_stb,
    output logic                  bus_we,
    output logic [addr_width-1:0] bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic [DATA_W-1:0]     bus_rdata,
    input  logic                  bus_ack,
    output state_t                dbg_state
);

    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(tmo_cycles - 1);

    state_t                  state_q;
    logic                    busy_q;
    logic                    hit_q;
    logic                    timeout_q;
    logic [DATA_W-1:0]       last_data_q;
    logic                    stb_q;
    logic [addr_width-1:0]   addr_q;
    logic [DATA_W-1:0]       mask_q;
    logic [DATA_W-1:0]       match_q;
    logic [PERIOD_W-1:0]     period_q;
    logic                    abort_q;   // stop seen during the current read

    logic                    tmo_zero;
    logic                    per_zero;
    logic [PERIOD_W-1:0]     per_load_val;

    // Period 0 behaves like period 1: always at least one idle gap.
    assign per_load_val = (period_q == '0) ? '0 : period_q - 1'b1;

    // The timeout counter is held at its reload value whenever no strobe is
    // out, so every new transaction starts with a full budget.
    io_poller_cnt #(.W(TMO_W)) u_tmo_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (!stb_q),
        .dec_i      (stb_q && !bus_ack),
        .load_val_i (TMO_LOAD),
        .zero_o     (tmo_zero)
    );

    io_poller_cnt #(.W(PERIOD_W)) u_per_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q != ST_WAIT),
        .dec_i      (state_q == ST_WAIT),
        .load_val_i (per_load_val),
        .zero_o     (per_zero)
    );

`ifdef IO_POLLER_WRACT_EN
    logic                  we_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [addr_width-1:0] wr_addr_q;
    logic [DATA_W-1:0]     wr_data_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            hit_q       <= 1'b0;
            timeout_q   <= 1'b0;
            last_data_q <= '0;
            stb_q       <= 1'b0;
            addr_q      <= '0;
            mask_q      <= '0;
            match_q     <= '0;
            period_q    <= '0;
            abort_q     <= 1'b0;
`ifdef IO_POLLER_WRACT_EN
            we_q        <= 1'b0;
            wdata_q     <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
`endif
        end else begin
            hit_q     <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    abort_q <= 1'b0;
                    if (start && !stop) begin
                        addr_q    <= cfg_addr;
                        mask_q    <= cfg_mask;
                        match_q   <= cfg_match;
                        period_q  <= cfg_period;
`ifdef IO_POLLER_WRACT_EN
                        wr_addr_q <= cfg_wr_addr;
                        wr_data_q <= cfg_wr_data;
`endif
                        busy_q    <= 1'b1;
                        stb_q     <= 1'b1;
                        state_q   <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (stop) begin
                        abort_q <= 1'b1;
                    end
                    if (bus_ack) begin
                        stb_q       <= 1'b0;
                        last_data_q <= bus_rdata;
                        if (abort_q || stop) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else if (masked_eq(bus_rdata, match_q, mask_q)) begin
                            hit_q <= 1'b1;
`ifdef IO_POLLER_WRACT_EN
                            // Write strobe rises one cycle later, with
                            // address/data already settled.
                            addr_q  <= wr_addr_q;
                            we_q    <= 1'b1;
                            wdata_q <= wr_data_q;
                            state_q <= ST_WRITE;
`else
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
`endif
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end else if (tmo_zero) begin
                        stb_q     <= 1'b0;
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (stop) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (per_zero) begin
                        stb_q   <= 1'b1;
                        state_q <= ST_READ;
                    end
                end
`ifdef IO_POLLER_WRACT_EN
                ST_WRITE: begin
                    if (!stb_q) begin
                        stb_q <= 1'b1;
                    end else if (bus_ack) begin
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (tmo_zero) begin
                        stb_q     <= 1'b0;
                        we_q      <= 1'b0;
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    stb_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign hit       = hit_q;
    assign timeout   = timeout_q;
    assign last_data = last_data_q;
    assign bus_stb   = stb_q;
    assign bus_addr  = addr_q;
    assign dbg_state = state_q;
`ifdef IO_POLLER_WRACT_EN
    assign bus_we    = we_q;
    assign bus_wdata = wdata_q;
`else
    assign bus_we    = 1'b0;
    assign bus_wdata = '0;
`endif

endmodule

// File: tb/tb_io_poller.sv
// tb_io_poller: self-checking bench for io_poller. A bus responder with a
// programmable ack latency serves read data from a small table; each poll
// session is predicted from the polling rules (reads, strobe/gap lengths,
// busy duration, outcome) and compared against a negedge monitor.
// Optional feature macro: IO_POLLER_WRACT_EN (write-action build).
module tb_io_poller;
  import io_poller_pkg::*;

  localparam int AW  = 4;
  localparam int TMO = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [31:0]   cfg_mask = '0;
  logic [31:0]   cfg_match = '0;
  logic [15:0]   cfg_period = '0;
`ifdef IO_POLLER_WRACT_EN
  logic [AW-1:0] cfg_wr_addr = '0;
  logic [31:0]   cfg_wr_data = '0;
`endif
  logic          busy, hit, timeout, bus_stb, bus_we, bus_ack;
  logic [31:0]   last_data, bus_wdata, bus_rdata;
  logic [AW-1:0] bus_addr;
  state_t        dbg_state;

  io_poller #(.addr_width(AW), .tmo_cycles(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .cfg_addr   (cfg_addr),
    .cfg_mask   (cfg_mask),
    .cfg_match  (cfg_match),
    .cfg_period (cfg_period),
`ifdef IO_POLLER_WRACT_EN
    .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data),
`endif
    .busy       (busy),
    .hit        (hit),
    .timeout    (timeout),
    .last_data  (last_data),
    .bus_stb    (bus_stb),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack),
    .dbg_state  (dbg_state)
  );

  // ---------------- responder ----------------
  logic [31:0] rd_mem [8];
  int          rd_idx = 0;
  int          stb_age = 0;
  int          lat = 0;
  logic        clr_idx = 1'b0;

  assign bus_ack   = bus_stb && (stb_age >= lat);
  assign bus_rdata = rd_mem[rd_idx[2:0]];

  always @(posedge clk) begin
    if (rst || !bus_stb || bus_ack) stb_age <= 0;
    else stb_age <= stb_age + 1;
    if (clr_idx) rd_idx <= 0;
    else if (bus_stb && bus_ack && !bus_we) rd_idx <= rd_idx + 1;
  end

  // ---------------- monitor ----------------
  logic          mon_clr = 1'b0;
  logic          prev_stb = 1'b0;
  int            busy_cyc, hit_cnt, tmo_cnt, rd_edges, wr_edges;
  int            gap_run, gap_min, gap_max, addr_err, wr_err, hit_busy;
  logic [AW-1:0] exp_addr = '0;
  logic [AW-1:0] exp_wr_addr = '0;
  logic [31:0]   exp_wr_data = '0;

  always @(negedge clk) begin
    if (mon_clr) begin
      prev_stb <= 1'b0; busy_cyc <= 0; hit_cnt <= 0; tmo_cnt <= 0;
      rd_edges <= 0; wr_edges <= 0; gap_run <= 0; gap_min <= 1000;
      gap_max <= 0; addr_err <= 0; wr_err <= 0; hit_busy <= 0;
    end else begin
      prev_stb <= bus_stb;
      if (busy) busy_cyc <= busy_cyc + 1;
      if (hit) hit_cnt <= hit_cnt + 1;
      if (timeout) tmo_cnt <= tmo_cnt + 1;
      if (hit && busy) hit_busy <= hit_busy + 1;
      if (bus_stb && !bus_we && bus_addr != exp_addr) addr_err <= addr_err + 1;
      if (bus_stb && bus_we && (bus_addr != exp_wr_addr || bus_wdata != exp_wr_data))
        wr_err <= wr_err + 1;
      if (bus_stb && !prev_stb) begin
        if (bus_we) begin
          wr_edges <= wr_edges + 1;
        end else begin
          rd_edges <= rd_edges + 1;
          if (rd_edges > 0) begin
            if (gap_run < gap_min) gap_min <= gap_run;
            if (gap_run > gap_max) gap_max <= gap_run;
          end
        end
        gap_run <= 0;
      end else if (!bus_stb && busy && rd_edges > 0) begin
        gap_run <= gap_run + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_last = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check_eq({tag, "_done"}, (k < 3000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic setup(input logic [31:0] mask, input logic [31:0] match,
                       input int period, input int latency, input logic [AW-1:0] addr);
    @(posedge clk); #1;
    mon_clr = 1'b1; clr_idx = 1'b1;
    cfg_mask = mask; cfg_match = match; cfg_period = 16'(period);
    cfg_addr = addr; exp_addr = addr; lat = latency;
`ifdef IO_POLLER_WRACT_EN
    cfg_wr_addr = AW'($urandom_range(0, 15));
    cfg_wr_data = $urandom;
    exp_wr_addr = cfg_wr_addr;
    exp_wr_data = cfg_wr_data;
`endif
    @(posedge clk); #1;
    mon_clr = 1'b0; clr_idx = 1'b0;
  endtask

  // One full poll: nmiss non-matching reads then a matching one (unless the
  // table was preloaded with fixed=1). Outcome predicted from the rules.
  task automatic run_session(input string tag, input logic [31:0] mask,
                             input logic [31:0] match, input int period,
                             input int latency, input int nmiss, input bit fixed);
    logic [31:0] v;
    int n, s, gap, busy_exp;
    bit  tmo_exp;
    if (!fixed) begin
      for (int i = 0; i < nmiss; i++) begin
        v = $urandom;
        if ((v & mask) == (match & mask)) v = v ^ (mask & (~mask + 32'd1));
        rd_mem[i] = v;
      end
      v = ($urandom & ~mask) | (match & mask);
      for (int i = nmiss; i < 8; i++) rd_mem[i] = v;
    end
    tmo_exp  = (latency + 1) > TMO;
    n        = tmo_exp ? 1 : nmiss + 1;
    s        = tmo_exp ? TMO : latency + 1;
    gap      = (period == 0) ? 1 : period;
    busy_exp = n * s + (n - 1) * gap;
`ifdef IO_POLLER_WRACT_EN
    if (!tmo_exp) busy_exp = busy_exp + 1 + s;
`endif
    if (!tmo_exp) model_last = rd_mem[nmiss];
    exp_q.push_back(32'(n));
    exp_q.push_back(32'(busy_exp));
    exp_q.push_back(tmo_exp ? 32'd0 : 32'd1);
    exp_q.push_back(tmo_exp ? 32'd1 : 32'd0);
    exp_q.push_back(model_last);

    setup(mask, match, period, latency, AW'($urandom_range(0, 15)));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(tag);
    repeat (2) @(negedge clk);

    check_eq({tag, "_reads"}, rd_edges, exp_q.pop_front());
    check_eq({tag, "_busy_cycles"}, busy_cyc, exp_q.pop_front());
    check_eq({tag, "_hits"}, hit_cnt, exp_q.pop_front());
    check_eq({tag, "_timeouts"}, tmo_cnt, exp_q.pop_front());
    check_eq({tag, "_last_data"}, last_data, exp_q.pop_front());
    check_eq({tag, "_addr_err"}, addr_err, 32'd0);
    if (n > 1) begin
      check_eq({tag, "_gap_min"}, gap_min, 32'(gap));
      check_eq({tag, "_gap_max"}, gap_max, 32'(gap));
    end
`ifdef IO_POLLER_WRACT_EN
    check_eq({tag, "_writes"}, wr_edges, tmo_exp ? 32'd0 : 32'd1);
    check_eq({tag, "_wr_err"}, wr_err, 32'd0);
`else
    check_eq({tag, "_hit_while_busy"}, hit_busy, 32'd0);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 32'd0);
    check_eq({tag, "_stb"}, bus_stb, 32'd0);
    check_eq({tag, "_we"}, bus_we, 32'd0);
    check_eq({tag, "_addr"}, bus_addr, 32'd0);
    check_eq({tag, "_wdata"}, bus_wdata, 32'd0);
    check_eq({tag, "_hit"}, hit, 32'd0);
    check_eq({tag, "_timeout"}, timeout, 32'd0);
    check_eq({tag, "_last_data"}, last_data, 32'd0);
    check_eq({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 8; i++) rd_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Combinational ack, single matching read.
    rd_mem[0] = 32'h0000_0005;
    run_session("basic", 32'h0F, 32'h05, 0, 0, 0, 1'b1);

    // Three misses then a hit with period 4.
    rd_mem[0] = 0; rd_mem[1] = 0; rd_mem[2] = 0; rd_mem[3] = 1;
    for (int i = 4; i < 8; i++) rd_mem[i] = 1;
    run_session("period4", 32'h1, 32'h1, 4, 0, 3, 1'b1);

    // Never acked -> timeout, last_data kept.
    run_session("no_ack", 32'hFF, 32'h12, 2, 1000, 0, 1'b0);
    // Ack on the last allowed strobe cycle, and one cycle too late.
    run_session("ack_edge", 32'hF0F0, 32'h1234, 1, TMO - 1, 1, 1'b0);
    run_session("ack_late", 32'hF0F0, 32'h1234, 1, TMO, 0, 1'b0);
    // Mask 0 hits at once; period 0 gives one gap cycle.
    run_session("mask0", 32'h0, $urandom, 3, 1, 0, 1'b0);
    run_session("period0", 32'hFFFF_FFFF, $urandom, 0, 0, 3, 1'b0);

    // stop during WAIT -> IDLE next cycle, no hit.
    for (int i = 0; i < 8; i++) rd_mem[i] = 32'h0000_0002;
    setup(32'h1, 32'h1, 20, 0, 4'h3);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("stopwait_in_wait", {31'd0, busy && !bus_stb}, 32'd1);
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    @(negedge clk);
    check_eq("stopwait_busy", busy, 32'd0);
    check_eq("stopwait_hits", hit_cnt, 32'd0);
    model_last = 32'h0000_0002;
    check_eq("stopwait_last", last_data, model_last);

    // start and stop together in IDLE -> nothing.
    setup(32'h0, 32'h0, 0, 0, 4'h1);
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    @(negedge clk);
    check_eq("startstop_busy", busy, 32'd0);
    check_eq("startstop_stb", bus_stb, 32'd0);

    // stop during READ: transaction finishes, no hit, data captured.
    for (int i = 0; i < 8; i++) rd_mem[i] = 32'h0000_00A0;
    setup(32'h1, 32'h1, 2, 3, 4'h5);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_idle("stopread");
    repeat (2) @(negedge clk);
    model_last = 32'h0000_00A0;
    check_eq("stopread_reads", rd_edges, 32'd1);
    check_eq("stopread_busy_cycles", busy_cyc, 32'd4);
    check_eq("stopread_hits", hit_cnt, 32'd0);
    check_eq("stopread_last", last_data, model_last);

    // Reset while strobing.
    setup(32'h1, 32'h1, 0, 1000, 4'h7);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("rst_pre_stb", bus_stb, 32'd1);
    @(negedge clk);
    check_all_zero("rst_mid");
    @(posedge clk); #1 rst = 1'b0;
    model_last = '0;

    // Randomized sessions.
    for (int t = 0; t < 14; t++) begin
      logic [31:0] m;
      int lt;
      m  = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      lt = ($urandom_range(0, 7) == 0) ? 40 : $urandom_range(0, 3);
      run_session($sformatf("rand%0d", t), m, $urandom, $urandom_range(0, 5), lt,
                  (m == 0) ? 0 : $urandom_range(0, 3), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_poller.md
# io_poller

Bus initiator for the I/O device bus (stb/we/addr/data/ack, responder acks via `ack`). It repeatedly reads one device register, compares the masked value against a match pattern, and flags a hit or a timeout. It sits between a controlling processor port (start/stop/config) and any device on the bus, e.g. the GPIO block, relieving software of busy-wait polling.

## Interface
- `addr_width`, 4: device bus address width.
- `tmo_cycles`, 15: max cycles `bus_stb` is held without `bus_ack` before timeout (1..255).

- `clk` in 1: system clock.
- `rst` in 1: reset. Synchronous to `clk`, active-high.
- `start` in 1: one-cycle pulse; begins polling, honoured only when idle.
- `stop` in 1: one-cycle pulse; aborts polling.
- `cfg_addr` in `addr_width`: device register address, latched on accepted `start`.
- `cfg_mask` in 32: compare mask, latched on `start`.
- `cfg_match` in 32: match pattern, latched on `start`.
- `cfg_period` in 16: idle cycles between reads, latched on `start`.
- `busy` out 1: high from accepted `start` until return to IDLE.
- `hit` out 1: one-cycle pulse on match.
- `timeout` out 1: one-cycle pulse on ack timeout.
- `last_data` out 32: last value read (unmasked).
- `bus_stb` out 1: transaction strobe.
- `bus_we` out 1: write enable.
- `bus_addr` out `addr_width`: transaction address.
- `bus_wdata` out 32: write data.
- `bus_rdata` in 32: read data, valid in the cycle `bus_ack` is high.
- `bus_ack` in 1: responder acknowledge; may be combinational from `bus_stb`.

## Operation
- States: IDLE, READ, WAIT, WRITE (only with macro).
- IDLE: `start` & ~`stop` latches config and enters READ next cycle (first read issues without a period wait). `start` outside IDLE is ignored. `stop` and `start` together in IDLE: `stop` wins, nothing happens.
- READ: `bus_stb`=1, `bus_we`=0, `bus_addr`=latched address. Each cycle `bus_ack`=1: capture `bus_rdata` into `last_data` and drop `bus_stb` next cycle.
  - If `(rdata & mask) == (match & mask)`, pulse `hit` next cycle. Then go to WRITE if enabled, otherwise IDLE.
  - If no match, go to WAIT.
  - Mask 0 always hits on the first read.
- Ack timeout: if no ack after `tmo_cycles` strobe cycles, drop `bus_stb`, pulse `timeout`, go to IDLE. `last_data` is unchanged.
- WAIT: `bus_stb`=0 for max(`cfg_period`,1) cycles, then READ. Period 0 gives back-to-back reads with 1 gap cycle.
- `stop`:
  - In WAIT: go to IDLE next cycle.
  - In READ: the current transaction finishes (ack or timeout), then go to IDLE with no `hit` and no further action. `timeout` still pulses if the transaction timed out.
  - In WRITE: ignored.
- `rst` mid-transaction: `bus_stb` drops in the cycle following `rst`. State, counters and outputs return to reset values.

## Timing
- Reset values: `bus_stb`, `bus_we`, `bus_addr`, `bus_wdata`, `busy`, `hit`, `timeout`, `last_data` all 0.
- `start` at cycle t: `busy` and `bus_stb` are 1 at t+1.
- With combinational ack: `bus_stb` is high exactly 1 cycle, `last_data` updates at t+2, `hit` pulses at t+2.
- `busy` falls in the cycle after the final transaction completes. `hit` and `timeout` pulse in that same cycle.
- `bus_we`, `bus_addr`, `bus_wdata` are stable whenever `bus_stb`=1. All outputs are registered.

## Configuration
- `IO_POLLER_WRACT_EN` defined:
  - Adds inputs `cfg_wr_addr` (`addr_width`) and `cfg_wr_data` (32), both latched on `start`, plus the WRITE state.
  - After a hit: one write transaction with `bus_we`=1, same ack and timeout rules as READ, then IDLE.
  - A timeout during the write pulses `timeout`.
- Undefined: no WRITE state, no extra ports, `bus_we` tied 0, `bus_wdata` tied 0.

## Structure
- Package `io_poller_pkg`: state encoding, `DATA_W`=32, `PERIOD_W`=16, `TMO_W`=8.
- One sub-module `io_poller_cnt`: loadable down-counter with zero flag. Instantiated once for the period and once for the ack timeout.

## Test plan
- Responder with combinational ack returns 0x0000_0005; mask 0x0F, match 0x05; `start` -> one strobe, `last_data`=5, `hit` at t+2, `busy` low at t+2.
- Data 0x0 for 3 reads then 0x1; mask 0x1, match 0x1, period 4 -> 4 strobes, 4 gap cycles between strobes, single `hit` after the 4th read.
- Responder never acks, `tmo_cycles`=15 -> `bus_stb` high exactly 15 cycles, then `timeout` pulse, `busy`=0, `last_data` unchanged.
- `stop` during WAIT -> IDLE next cycle, no `hit`. `start`+`stop` in the same cycle in IDLE -> `busy` stays 0.
- `rst` while `bus_stb`=1 -> all outputs 0 the next cycle. A later `start` operates normally.
- With `IO_POLLER_WRACT_EN`: hit on address 0, `cfg_wr_addr`=1, `cfg_wr_data`=0xFF -> read then a write strobe with `bus_we`=1, `bus_addr`=1, `bus_wdata`=0xFF.
